// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package mult_pkg;

  // Operand width and step-counter width defaults (2**CNT_W_DEF == N_DEF)
  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 2;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sum4b.sv
// 4-bit unsigned combinational adder with carry-out.
module sum4b (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] S,
  output logic       Cout
);

  // Zero-extend both operands so the fifth bit carries out
  always_comb begin
    {Cout, S} = {1'b0, A} + {1'b0, B};
  end

endmodule

// File: rtl/mult4b_ctrl.sv
// Sequential unsigned multiplier: one shared 4-bit adder, add/shift per step.
module mult4b_ctrl
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     add_s;
  logic             add_co;
  logic [2*N:0]     shift_w;

  // The only arithmetic resource: partial product plus multiplicand
  sum4b u_add (
    .A    (acc_q),
    .B    (m_q),
    .S    (add_s),
    .Cout (add_co)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    // Carry drops into ACC msb, ACC lsb drops into Q msb, zero enters on top
    shift_w = {c_q, acc_q, q_q} >> 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
          busy_d  = 1'b1;
        end
      end
      ADD: begin
        if (q_q[0]) begin
          {c_d, acc_d} = {add_co, add_s};
        end else begin
          c_d = 1'b0;
        end
        state_d = SHIFT;
        busy_d  = 1'b1;
      end
      SHIFT: begin
        c_d   = shift_w[2*N];
        acc_d = shift_w[2*N-1:N];
        q_d   = shift_w[N-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          p_d     = shift_w[2*N-1:0];
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ADD;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        // start is deliberately not looked at here
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand/accumulator and output registers; reset abandons any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_mult4b_ctrl.sv
// Scoreboard bench for mult4b_ctrl: expected products and done cycles queued at start.
module tb_mult4b_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;

  int n_cmp;
  int n_err;
  int cyc;

  typedef struct {
    logic [7:0] p;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  mult4b_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_spurious", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("P_at_done", {24'd0, P}, {24'd0, e.p});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] p, output int c0);
    exp_t e;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    c0    = cyc;
    e.p   = p;
    e.cyc = cyc + 9;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;

    repeat (2) @(negedge clk);
    chk("rst_P", {24'd0, P}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // 3 x 5 with busy/done cycle trace
    do_op(4'd3, 4'd5, 8'h0F, c0);
    for (int k = 1; k <= 10; k++) begin
      wait_cyc(c0 + k);
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, {31'd0, (k >= 1 && k <= 8)});
    end
    wait_idle();

    // Carry into ACC, then a mixed pattern
    do_op(4'd15, 4'd15, 8'hE1, c0);
    wait_idle();
    do_op(4'd9, 4'd13, 8'h75, c0);
    wait_idle();

    // Zero operands; previous product must hold while computing
    do_op(4'd7, 4'd0, 8'h00, c0);
    wait_cyc(c0 + 5);
    chk("P_hold", {24'd0, P}, 32'h75);
    wait_idle();
    do_op(4'd0, 4'd11, 8'h00, c0);
    wait_idle();

    // Starts while busy and in DONE are ignored; operand changes have no effect
    do_op(4'd2, 4'd3, 8'h06, c0);
    wait_cyc(c0 + 3);
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c0 + 9);
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    do_op(4'd15, 4'd15, 8'hE1, c0);
    wait_idle();

    // start held high: one result every 10 cycles
    begin
      exp_t e;
      @(negedge clk);
      A = 4'd4; B = 4'd4; start = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
        e.p   = 8'h10;
        e.cyc = c0 + 9 + 10 * k;
        sb.push_back(e);
      end
      wait_cyc(c0 + 21);
      start = 1'b0;
      wait_idle();
    end

    // Reset in the middle of an operation
    do_op(4'd15, 4'd15, 8'hE1, c0);
    wait_cyc(c0 + 5);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_P", {24'd0, P}, 32'h00);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_op(4'd9, 4'd13, 8'h75, c0);
    wait_idle();

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult4b_ctrl.md
Name: mult4b_ctrl

Overview:
Sequential 4x4 unsigned shift-and-add multiplier controller. It time-shares one combinational 4-bit adder (sum4b) across N add/shift steps to produce an 8-bit product. The block owns the FSM, operand/accumulator registers and the start/busy/done handshake. The adder is the only arithmetic resource used.

Parameters:
N, 4, operand width. Fixed to the sum4b width; no other value is supported.
CNT_W, 2, step-counter width; 2^CNT_W = N.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
start  input  1  request; sampled only in IDLE
A  input  N  multiplicand, captured when start is accepted
B  input  N  multiplier, captured when start is accepted
busy  output  1  high in ADD and SHIFT states
done  output  1  one-cycle pulse, high in DONE state
P  output  2N  product register; holds last result until the next DONE

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, P=0, done=0, busy=0, M=Q=ACC=0, C=0, cnt=0. Applies mid-operation: the operation is abandoned and no done pulse follows.
- Internal registers:
  - M[N-1:0]: multiplicand
  - Q[N-1:0]: multiplier, shifted down as steps complete
  - ACC[N-1:0]: upper partial product
  - C: adder carry-out
  - cnt[CNT_W-1:0]: step counter
- Adder hookup: sum4b.A=ACC, sum4b.B=M, outputs {Cout,S}.
- IDLE:
  - If start=1: M<=A, Q<=B, ACC<=0, C<=0, cnt<=0, go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If Q[0]=1: {C,ACC}<={Cout,S}.
  - Else: C<=0 and ACC is unchanged.
  - Always go to SHIFT.
- SHIFT:
  - {C,ACC,Q}<={C,ACC,Q}>>1 with a 0 shifted in at the top (the carry enters ACC[N-1], ACC[0] enters Q[N-1]).
  - cnt<=cnt+1.
  - If cnt==N-1 (before increment): P<={ACC,Q} shifted value, go to DONE.
  - Else go to ADD.
- DONE: done=1 for exactly this cycle, busy=0, go to IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge 0 → done=1 and P valid during cycle 2N+1, i.e. cycle 9 for N=4.
  - P is stable from that edge until the next DONE.
- Throughput: start held high gives one result every 2N+2 = 10 cycles (DONE→IDLE→accept).
- start while busy or in DONE: ignored. A and B changes after acceptance have no effect.
- Arithmetic: unsigned. The 2N-bit product never overflows. cnt wraps naturally but is reloaded at acceptance.
- FSM encoding (2 bits): IDLE=0, ADD=1, SHIFT=2, DONE=3.
- Outputs are driven from registers/state only; no combinational path from start to busy or done.

Decomposition:
- Shared package/header mult_pkg:
  - state encodings (IDLE, ADD, SHIFT, DONE)
  - N and CNT_W defaults
- Sub-module: the existing sum4b adder is instantiated once as the datapath (instance u_add).
- FSM and registers live in mult4b_ctrl; no further sub-modules.

Test Plan:
- Reset low 2 cycles, then high → P=0x00, busy=0, done=0. start=1, A=3, B=5 for one cycle → busy=1 cycles 1–8, done=1 only at cycle 9, P=0x0F.
- A=15, B=15 (exercises adder carry into ACC) → P=0xE1 at done. Also A=9, B=13 → P=0x75.
- A=7, B=0, and separately A=0, B=11 → P=0x00 with done pulse at cycle 9. Previous P holds until then.
- Pulse start with A=2, B=3; reassert start with A=15, B=15 at cycles 3 and 9 → ignored, single done with P=0x06. Next accepted start produces 0xE1.
- start held high with A=4, B=4 → done pulses at cycles 9, 19, 29, P=0x10 each time.
- Reset asserted at cycle 5 of an A=15, B=15 operation → next edge: IDLE, P=0, busy=0, no done pulse. A fresh start then yields a correct result.
